lr_car_queue_monitor: RTL and testbench



---
 rtl/lr_car_queue_monitor_if.sv | 20 ++
 rtl/lr_car_queue_monitor.sv | 73 +++++++
 tb/tb_lr_car_queue_monitor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lr_car_queue_monitor_if.sv
// lr_car_queue_monitor_if: sensor/light inputs and queue/safety status outputs of the car queue monitor
interface lr_car_queue_monitor_if #(parameter int CNT_W = 4);
  logic             car_arrive;
  logic [2:0]       hw_light;
  logic [2:0]       lr_light;
  logic             lr_has_car;
  logic [CNT_W-1:0] queue_count;
  logic             depart;
  logic             overflow;
  logic             safety_err;
  logic [1:0]       err_code;
  modport master (
    output car_arrive, hw_light, lr_light,
    input  lr_has_car, queue_count, depart, overflow, safety_err, err_code
  );
  modport slave (
    input  car_arrive, hw_light, lr_light,
    output lr_has_car, queue_count, depart, overflow, safety_err, err_code
  );
endinterface

// File: rtl/lr_car_queue_monitor.sv
// lr_car_queue_monitor: local-road car queue released on green, plus a sticky light-protocol safety monitor
module lr_car_queue_monitor #(
  parameter int QUEUE_MAX     = 15,
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  lr_car_queue_monitor_if.slave          bus
);
  localparam int TW = DEPART_CYCLES > 1 ? $clog2(DEPART_CYCLES) : 1;
  typedef enum logic {WAIT, DRIVE} state_t;
  state_t           state;
  logic [TW-1:0]    timer, tnow;
  logic [CNT_W-1:0] count;
  logic             dep_q, ovf_q, err_q;
  logic [1:0]       code_q, code_now;
  logic [2:0]       prev_hw, prev_lr;
  logic             green, fire, leave, full;
  function automatic logic legal(input logic [2:0] x);
    return x == 3'b000 || x == 3'b001 || x == 3'b010 || x == 3'b100;
  endfunction
  function automatic logic moving(input logic [2:0] x);
    return x == 3'b001 || x == 3'b010;
  endfunction
  always_comb begin
    green    = bus.lr_light == 3'b001;
    tnow     = state == DRIVE ? timer : '0;
    fire     = green && tnow == TW'(DEPART_CYCLES - 1);
    leave    = fire && count != '0;
    full     = count == CNT_W'(QUEUE_MAX);
    // first matching term wins, giving priority illegal > conflict > skipped yellow
    code_now = (!legal(bus.hw_light) || !legal(bus.lr_light)) ? 2'd2 :
               (moving(bus.hw_light) && moving(bus.lr_light)) ? 2'd1 :
               ((prev_hw == 3'b001 && bus.hw_light == 3'b100) ||
                (prev_lr == 3'b001 && bus.lr_light == 3'b100)) ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT;
      timer   <= '0;
      count   <= '0;
      dep_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      prev_hw <= 3'b000;
      prev_lr <= 3'b000;
    end else begin
      state   <= green ? DRIVE : WAIT;
      timer   <= (green && !fire) ? tnow + 1'b1 : '0;
      dep_q   <= leave;
      if (bus.car_arrive && !leave && !full)
        count <= count + 1'b1;
      else if (!bus.car_arrive && leave)
        count <= count - 1'b1;
      if (bus.car_arrive && !leave && full)
        ovf_q <= 1'b1;
      prev_hw <= bus.hw_light;
      prev_lr <= bus.lr_light;
      if (!err_q && code_now != 2'd0) begin
        err_q  <= 1'b1;
        code_q <= code_now;
      end
    end
  end
  assign bus.queue_count = count;
  assign bus.lr_has_car  = count != '0;
  assign bus.depart      = dep_q;
  assign bus.overflow    = ovf_q;
  assign bus.safety_err  = err_q;
  assign bus.err_code    = code_q;
endmodule

// File: tb/tb_lr_car_queue_monitor.sv
// tb_lr_car_queue_monitor: directed plan scenarios plus randomized traffic checked against a cycle model
module tb_lr_car_queue_monitor;
  localparam int QMAX = 15;
  localparam int DEP  = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int m_cnt, m_run, m_dep, m_ovf, m_code;
  logic [2:0] m_ph, m_pl;
  lr_car_queue_monitor_if #(.CNT_W(4)) bus();
  lr_car_queue_monitor #(.QUEUE_MAX(QMAX), .CNT_W(4), .DEPART_CYCLES(DEP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit ok_code(input logic [2:0] x);
    return x == 3'b000 || x == 3'b001 || x == 3'b010 || x == 3'b100;
  endfunction
  function automatic bit goes(input logic [2:0] x);
    return x == 3'b001 || x == 3'b010;
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_dep = 0; m_ovf = 0; m_code = 0;
    m_ph = 3'b000; m_pl = 3'b000;
  endtask
  task automatic model_step(input bit a, input logic [2:0] h, input logic [2:0] l);
    int code;
    bit fire;
    fire = 0;
    if (l == 3'b001) begin
      m_run++;
      if (m_run == DEP) begin
        m_run = 0;
        fire = 1;
      end
    end else m_run = 0;
    m_dep = (fire && m_cnt > 0) ? 1 : 0;
    if (a && m_dep == 0) begin
      if (m_cnt == QMAX) m_ovf = 1;
      else m_cnt++;
    end else if (!a && m_dep == 1) m_cnt--;
    if (!ok_code(h) || !ok_code(l)) code = 2;
    else if (goes(h) && goes(l)) code = 1;
    else if ((m_ph == 3'b001 && h == 3'b100) || (m_pl == 3'b001 && l == 3'b100)) code = 3;
    else code = 0;
    if (m_code == 0) m_code = code;
    m_ph = h;
    m_pl = l;
  endtask
  task automatic check_all();
    chk("queue_count", int'(bus.queue_count), m_cnt);
    chk("lr_has_car", int'(bus.lr_has_car), m_cnt != 0 ? 1 : 0);
    chk("depart", int'(bus.depart), m_dep);
    chk("overflow", int'(bus.overflow), m_ovf);
    chk("safety_err", int'(bus.safety_err), m_code != 0 ? 1 : 0);
    chk("err_code", int'(bus.err_code), m_code);
  endtask
  // called at a negedge; drives one cycle of inputs and checks at the following negedge
  task automatic cyc(input bit a, input logic [2:0] h, input logic [2:0] l);
    bus.car_arrive = a;
    bus.hw_light = h;
    bus.lr_light = l;
    model_step(a, h, l);
    @(negedge clk);
    check_all();
  endtask
  // asserts reset in the low phase, checks outputs before any clock edge, releases at the next negedge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", int'(bus.queue_count), 0);
    chk("rst_has_car", int'(bus.lr_has_car), 0);
    chk("rst_depart", int'(bus.depart), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_err", int'(bus.safety_err), 0);
    chk("rst_code", int'(bus.err_code), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [2:0] h, l;
    bus.car_arrive = 1'b0;
    bus.hw_light = 3'b000;
    bus.lr_light = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    // four arrivals while local road is red
    cyc(1, 3'b001, 3'b100);
    chk("has_car_after_first", int'(bus.lr_has_car), 1);
    repeat (3) cyc(1, 3'b001, 3'b100);
    chk("count_4", int'(bus.queue_count), 4);
    cyc(0, 3'b010, 3'b100);
    repeat (12) cyc(0, 3'b100, 3'b001);
    chk("drained", int'(bus.queue_count), 0);
    repeat (4) cyc(0, 3'b100, 3'b001);
    // arrival coinciding with departure at count 2
    cyc(0, 3'b100, 3'b010);
    cyc(0, 3'b100, 3'b100);
    repeat (2) cyc(1, 3'b100, 3'b100);
    repeat (2) cyc(0, 3'b100, 3'b001);
    cyc(1, 3'b100, 3'b001);
    chk("same_cycle_count", int'(bus.queue_count), 2);
    chk("same_cycle_depart", int'(bus.depart), 1);
    cyc(0, 3'b100, 3'b010);
    repeat (14) cyc(1, 3'b100, 3'b100);
    chk("full_count", int'(bus.queue_count), 15);
    chk("overflow_set", int'(bus.overflow), 1);
    repeat (3) cyc(0, 3'b100, 3'b100);
    chk("overflow_sticky", int'(bus.overflow), 1);
    // yellow clears a partial departure count
    do_reset();
    cyc(1, 3'b100, 3'b100);
    repeat (2) cyc(0, 3'b100, 3'b001);
    cyc(0, 3'b100, 3'b010);
    repeat (2) cyc(0, 3'b100, 3'b001);
    chk("yellow_no_depart", int'(bus.queue_count), 1);
    do_reset();
    cyc(0, 3'b001, 3'b010);
    chk("conflict_code", int'(bus.err_code), 1);
    cyc(0, 3'b011, 3'b100);
    chk("code_not_overwritten", int'(bus.err_code), 1);
    do_reset();
    cyc(0, 3'b001, 3'b100);
    cyc(0, 3'b100, 3'b100);
    chk("skip_yellow_code", int'(bus.err_code), 3);
    do_reset();
    cyc(0, 3'b011, 3'b100);
    chk("illegal_code", int'(bus.err_code), 2);
    do_reset();
    cyc(0, 3'b011, 3'b001);
    chk("priority_code", int'(bus.err_code), 2);
    // mid-departure reset with a populated queue and a latched error
    do_reset();
    repeat (6) cyc(1, 3'b100, 3'b100);
    cyc(0, 3'b001, 3'b010);
    repeat (2) cyc(0, 3'b100, 3'b001);
    chk("pre_reset_count", int'(bus.queue_count), 6);
    do_reset();
    // randomized traffic with periodic resets
    for (int i = 0; i < 800; i++) begin
      if (i % 80 == 79) do_reset();
      if ($urandom_range(0, 49) == 0) begin
        h = 3'($urandom_range(0, 7));
        l = 3'($urandom_range(0, 7));
      end else begin
        h = $urandom_range(0, 9) == 0 ? 3'b010 : 3'b100;
        case ($urandom_range(0, 9))
          0, 1:    l = 3'b010;
          2:       l = 3'b100;
          default: l = 3'b001;
        endcase
      end
      cyc(1'($urandom_range(0, 2) == 0), h, l);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
